// File: rtl/piso_serializer.sv
// MSB-first PISO: word accepted at edge N shows its MSB on x_o after N; ready_o only in IDLE or on the final bit (backpressure).
// Optional macro PISO_PARITY_EN appends an even-parity bit, making each frame WIDTH+1 cycles.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             x_o,
    output logic             frame_o,
    output logic             done_o
);

`ifdef PISO_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] LAST    = CW'(SW - 1);
    localparam logic [CW-1:0] LAST_M1 = CW'(SW - 2);
    localparam logic [CW-1:0] ONE     = CW'(1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          last_bit;
    logic          accept;

    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
    assign ready_o  = (state_q == IDLE) || done_q;
    assign accept   = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
`ifdef PISO_PARITY_EN
            // Parity rides in the LSB so it shifts out right after the data LSB.
            shreg_d = {data_i, ^data_i};
`else
            shreg_d = data_i;
`endif
        end else if (state_q == SHIFT) begin
            shreg_d = {shreg_q[SW-2:0], 1'b0};
            cnt_d   = cnt_q + ONE;
            if (last_bit) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    // done is registered one edge early so it lines up with the final bit on x_o.
    assign done_d = (state_q == SHIFT) && (cnt_q == LAST_M1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // The register drains to zero on the final shift, so x_o idles low.
    assign x_o     = shreg_q[SW-1];
    assign frame_o = (state_q == SHIFT);
    assign done_o  = done_q;

    a_valid_known: assert property (@(posedge clk) disable iff (!reset)
        ready_o |-> !$isunknown(valid_i));

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in / serial-out transmitter, the sending end of the 4-bit serial link whose receiver is our serial-in / parallel-out shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out MSB-first on a single wire, one bit per clk.
- Asserts a frame strobe while bits are live.
- Bit order is chosen so a downstream SIPO that shifts in at its LSB ends up holding the original word after WIDTH clocks.

Parameters:
- WIDTH, 4, word width in bits; legal range 2 to 32.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_i  input  WIDTH  parallel word to transmit.
- valid_i  input  1  data_i holds a word to send.
- ready_o  output  1  block can accept a word this cycle.
- x_o  output  1  serial data out, registered.
- frame_o  output  1  high while x_o carries a valid bit, registered.
- done_o  output  1  one-cycle pulse coincident with the final bit of a word, registered.

Behaviour:
- Reset is asynchronous and active-low: reset low forces the block to its reset state immediately, regardless of clk. Clock is clk.
- Reset values:
  - state = IDLE; shift register = 0; bit counter = 0.
  - x_o = 0, frame_o = 0, done_o = 0, ready_o = 1.
- State machine has two states:
  - IDLE: ready_o = 1; x_o = 0; frame_o = 0.
  - SHIFT: frame_o = 1; x_o = current MSB of the shift register.
- Accept rule:
  - A word is accepted on a rising edge where valid_i && ready_o.
  - data_i is loaded into the shift register, counter is cleared, state goes to SHIFT.
  - data_i is sampled only at acceptance; later changes have no effect.
- Latency: a word accepted at edge N puts its MSB on x_o during the cycle after edge N. Bit k (MSB = bit WIDTH-1) appears WIDTH-1-k cycles later.
- Shifting:
  - Each edge in SHIFT shifts the register left by one, filling with 0, and increments the counter.
  - Counter width is clog2(WIDTH+1).
- Last bit (counter == WIDTH-1):
  - done_o = 1 and ready_o = 1.
  - If valid_i is high on that edge, the next word loads and its MSB follows with no gap. frame_o stays high continuously.
  - Otherwise the block returns to IDLE and frame_o drops on the next cycle.
- In SHIFT before the last bit, ready_o = 0. valid_i is ignored and the word must be held by the sender.
- valid_i low in IDLE: no state change and no output activity.
- Reset mid-frame:
  - Transmission aborts immediately and all outputs return to reset values.
  - The partial word is discarded; no done_o pulse is produced.
- X on valid_i while ready_o = 1 is illegal; assertion checkers flag it.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits, latched at acceptance) is sent as one extra cycle after the LSB, with frame_o high. A frame is therefore WIDTH+1 cycles.
  - done_o and ready_o assert in the parity cycle instead of the LSB cycle.
  - Back-to-back rules are unchanged, applied at the parity cycle.
- Undefined: frames are exactly WIDTH cycles, with no parity logic or parity register synthesised.

Test Plan:
- Reset: hold reset low for 3 cycles with valid_i = 1 and data_i = 4'hF -> x_o = 0, frame_o = 0, done_o = 0, ready_o = 1; no word accepted.
- Single word: accept 4'b1011 -> x_o = 1,0,1,1 on the 4 following cycles; frame_o high exactly 4 cycles; done_o high only on the 4th; ready_o low on cycles 1-3.
- Back-to-back: 4'b1011 then 4'b0110 with valid_i held -> x_o = 1,0,1,1,0,1,1,0; frame_o high 8 consecutive cycles; done_o pulses on the 4th and 8th.
- Mid-frame reset: assert reset after 2 bits of 4'b1100 -> outputs go to reset values immediately; the next accepted 4'b0001 transmits 0,0,0,1 cleanly.
- Loopback: x_o feeds our SIPO, enabled by frame_o, for words 4'h0, 4'h5, 4'hA, 4'hF -> SIPO output equals the sent word on the cycle after done_o.
- Parity (PISO_PARITY_EN): word 4'b0111 -> x_o = 0,1,1,1,1; frame_o high 5 cycles; done_o on the 5th. Word 4'b0110 -> parity bit 0.
